// File: rtl/pkt_enqueue_control_pkg.sv
// Shared constants for the enqueue side: queue geometry and the header layout that the
// output selector parses, plus the 64-bit-per-step CRC32 update.
package pkt_enqueue_control_pkg;

    localparam int unsigned DATA_WIDTH       = 64;
    localparam int unsigned PORT_NUB_TOTAL   = 16;
    localparam int unsigned PORT_WIDTH       = $clog2(PORT_NUB_TOTAL);
    localparam int unsigned PRI_NUM_BIT      = 3;
    localparam int unsigned PRI_NUM_TOTAL    = 1 << PRI_NUM_BIT;
    localparam int unsigned CRC32_LENGTH     = 32;
    localparam int unsigned DATABUF_HIGH_NUM = 7;
    localparam int unsigned DATABUF_DEPTH    = 1 << DATABUF_HIGH_NUM;

    localparam int unsigned HDR_PRI_LSB = 0;
    localparam int unsigned HDR_CRC_LSB = HDR_PRI_LSB + PRI_NUM_BIT;
    localparam int unsigned HDR_CNT_LSB = HDR_CRC_LSB + CRC32_LENGTH;

    localparam logic [31:0] CRC32_POLY = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StCrcw,
        StHdr,
        StDump,
        StDrop
    } enq_state_e;

    // Reflected CRC32, word bit 0 shifted in first (byte 0 of the word leads).
    function automatic logic [31:0] crc32_step64(input logic [31:0] crc, input logic [63:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 64; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ CRC32_POLY;
            else                c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_64bit.sv
// CRC32 accumulator consuming one 64-bit word per enabled cycle.
module crc32_64bit
    import pkt_enqueue_control_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        crc_en,
    input  logic [63:0] data_in,
    output logic [31:0] crc_out
);

    logic [31:0] crc_q;

    // Synchronous clear so the enqueue FSM can restart the CRC on any control word.
    always_ff @(posedge clk) begin
        if (rst)         crc_q <= CRC32_INIT;
        else if (crc_en) crc_q <= crc32_step64(crc_q, data_in);
    end

    assign crc_out = ~crc_q;

endmodule

// File: rtl/pkt_enqueue_control.sv
// Buffers one ingress packet, computes its CRC32, then writes header + payload into the
// output queue selected by the control word's destination.
module pkt_enqueue_control
    import pkt_enqueue_control_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_sop,
    input  logic                      wr_eop,
    input  logic                      wr_vld,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    output logic                      in_ready,
    input  logic [PORT_NUB_TOTAL-1:0] full,
    output logic                      q_wr_en,
    output logic [PORT_WIDTH-1:0]     q_wr_sel,
    output logic [DATA_WIDTH-1:0]     q_wr_data,
    output logic                      error
);

    localparam int unsigned CW = DATABUF_HIGH_NUM;

    enq_state_e state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d, rd_ptr_q, rd_ptr_d;
    logic [PORT_WIDTH-1:0]  dest_q, dest_d;
    logic [PRI_NUM_BIT-1:0] pri_q, pri_d;
    logic                   in_ready_q, in_ready_d;
    logic                   q_wr_en_q, q_wr_en_d;
    logic [PORT_WIDTH-1:0]  q_wr_sel_q, q_wr_sel_d;
    logic [DATA_WIDTH-1:0]  q_wr_data_q, q_wr_data_d;
    logic                   error_q, error_d;

    logic                   buf_we;
    logic [DATA_WIDTH-1:0]  buf_rd_q;
    logic [DATA_WIDTH-1:0]  mem [DATABUF_DEPTH];

    logic                    crc_clr, crc_en, crc_rst;
    logic [CRC32_LENGTH-1:0] crc_out;
    logic [DATA_WIDTH-1:0]   header;
    logic                    dest_full;

    assign crc_rst   = rst_n | crc_clr;
    assign dest_full = full[dest_q];

    crc32_64bit u_crc (
        .clk     (clk),
        .rst     (crc_rst),
        .crc_en  (crc_en),
        .data_in (wr_data),
        .crc_out (crc_out)
    );

    always_comb begin
        header = '0;
        header[HDR_PRI_LSB +: PRI_NUM_BIT]  = pri_q;
        header[HDR_CRC_LSB +: CRC32_LENGTH] = crc_out;
        header[HDR_CNT_LSB +: CW]           = cnt_q;
    end

    // Read address is the next pointer so buf_rd_q always holds mem[rd_ptr_q].
    always_ff @(posedge clk) begin
        if (buf_we) mem[cnt_q] <= wr_data;
        buf_rd_q <= mem[rd_ptr_d];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_ptr_d    = rd_ptr_q;
        dest_d      = dest_q;
        pri_d       = pri_q;
        in_ready_d  = in_ready_q;
        q_wr_en_d   = 1'b0;
        q_wr_sel_d  = q_wr_sel_q;
        q_wr_data_d = q_wr_data_q;
        error_d     = 1'b0;
        buf_we      = 1'b0;
        crc_clr     = 1'b0;
        crc_en      = 1'b0;

        if (wr_vld && !in_ready_q) error_d = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (wr_vld) begin
                    if (wr_sop && !wr_eop) begin
                        dest_d  = wr_data[PORT_WIDTH-1:0];
                        pri_d   = wr_data[PORT_WIDTH +: PRI_NUM_BIT];
                        cnt_d   = '0;
                        crc_clr = 1'b1;
                        state_d = StRecv;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            StRecv: begin
                if (wr_vld) begin
                    if (wr_sop) begin
                        // Abandon the packet in flight; this control word starts a new one.
                        error_d = 1'b1;
                        dest_d  = wr_data[PORT_WIDTH-1:0];
                        pri_d   = wr_data[PORT_WIDTH +: PRI_NUM_BIT];
                        cnt_d   = '0;
                        crc_clr = 1'b1;
                        if (wr_eop) state_d = StIdle;
                    end else if (cnt_q == '1) begin
                        error_d = 1'b1;
                        state_d = wr_eop ? StIdle : StDrop;
                    end else begin
                        buf_we = 1'b1;
                        crc_en = 1'b1;
                        cnt_d  = cnt_q + 1'b1;
                        if (wr_eop) begin
                            state_d    = StCrcw;
                            in_ready_d = 1'b0;
                        end
                    end
                end
            end
            StCrcw, StHdr: begin
                rd_ptr_d = '0;
                if (!dest_full) begin
                    q_wr_en_d   = 1'b1;
                    q_wr_sel_d  = dest_q;
                    q_wr_data_d = header;
                    state_d     = StDump;
                end else begin
                    state_d = StHdr;
                end
            end
            StDump: begin
                if (!dest_full) begin
                    q_wr_en_d   = 1'b1;
                    q_wr_sel_d  = dest_q;
                    q_wr_data_d = buf_rd_q;
                    rd_ptr_d    = rd_ptr_q + 1'b1;
                    if (rd_ptr_q == cnt_q - 1'b1) begin
                        state_d    = StIdle;
                        in_ready_d = 1'b1;
                    end
                end
            end
            StDrop: begin
                if (wr_vld && wr_eop) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rd_ptr_q    <= '0;
            dest_q      <= '0;
            pri_q       <= '0;
            in_ready_q  <= 1'b1;
            q_wr_en_q   <= 1'b0;
            q_wr_sel_q  <= '0;
            q_wr_data_q <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            dest_q      <= dest_d;
            pri_q       <= pri_d;
            in_ready_q  <= in_ready_d;
            q_wr_en_q   <= q_wr_en_d;
            q_wr_sel_q  <= q_wr_sel_d;
            q_wr_data_q <= q_wr_data_d;
            error_q     <= error_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign q_wr_en   = q_wr_en_q;
    assign q_wr_sel  = q_wr_sel_q;
    assign q_wr_data = q_wr_data_q;
    assign error     = error_q;

endmodule
